trojan_rx_32_128: RTL

TROJAN_RX_32_128 -- requirements
Module: trojan_rx_32_128

---
 rtl/trojan_rx_32_128.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/trojan_rx_32_128.sv
// trojan_rx_32_128: reassembles a 128-bit key from a 2-bit-per-cycle leak
// channel and presents it downstream as four 32-bit words over a
// valid/ready handshake. Truncated frames raise a one-cycle err pulse.
// Symbols that arrive while the block is still emitting words set a
// sticky drop flag.
module trojan_rx_32_128 (
  input  logic         clk,
  input  logic         rst_all_n,
  input  logic         leak_en,
  input  logic [1:0]   leak_sym,
  input  logic         word_ready,
  output logic [127:0] key_out,
  output logic [31:0]  word_data,
  output logic         word_valid,
  output logic         busy,
  output logic         err,
  output logic         drop,
  output logic [7:0]   frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_OUT, S_DRAIN} state_e;

  state_e         state_q, state_d;
  logic           leak_en_q;
  logic [127:0]   asm_q, asm_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     fcnt_q, fcnt_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           wvalid_q, wvalid_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           drop_q, drop_d;

  logic [127:0]   shifted;
  logic           rise;
  logic [1:0]     idx_nxt;

  // Next-state logic for the receive / output / drain sequence
  always_comb begin
    state_d  = state_q;
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    idx_d    = idx_q;
    fcnt_d   = fcnt_q;
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    err_d    = 1'b0;
    drop_d   = drop_q;
    // New symbols enter at the top so the first one ends up in bits [1:0]
    shifted  = {leak_sym, asm_q[127:2]};
    // A frame only starts on a true rising edge of leak_en
    rise     = leak_en & ~leak_en_q;
    idx_nxt  = idx_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          asm_d   = shifted;
          cnt_d   = 6'd1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (leak_en) begin
          asm_d = shifted;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            // Last symbol: publish the key and first word on the same edge
            key_d    = shifted;
            fcnt_d   = fcnt_q + 8'd1;
            idx_d    = 2'd0;
            wdata_d  = shifted[31:0];
            wvalid_d = 1'b1;
            state_d  = S_OUT;
          end
        end else begin
          err_d   = 1'b1;
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (leak_en) begin
          drop_d = 1'b1;
        end
        if (word_ready) begin
          if (idx_q == 2'd3) begin
            wvalid_d = 1'b0;
            state_d  = S_DRAIN;
          end else begin
            idx_d   = idx_nxt;
            wdata_d = key_q[{idx_nxt, 5'd0} +: 32];
          end
        end
      end
      S_DRAIN: begin
        // The low cycle that ends the drain also arms the edge detector
        if (!leak_en) begin
          state_d = S_IDLE;
        end else if (!leak_en_q) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; leak_en_q resets high to block mid-frame starts
  always_ff @(posedge clk or negedge rst_all_n) begin
    if (!rst_all_n) begin
      state_q   <= S_IDLE;
      leak_en_q <= 1'b1;
      asm_q     <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      idx_q     <= '0;
      fcnt_q    <= '0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      leak_en_q <= leak_en;
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      fcnt_q    <= fcnt_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign key_out    = key_q;
  assign word_data  = wdata_q;
  assign word_valid = wvalid_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign drop       = drop_q;
  assign frame_cnt  = fcnt_q;

endmodule
